// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator scheduler slice: FSM state encoding and
// default sizing for floors and door timing.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    TRAVEL = 2'd2,
    DOOR   = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_FLOORS  = 4;
  localparam int DEF_FLOOR_W     = 2;
  localparam int DEF_DOOR_CYCLES = 8;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Call/dispatch bundle between the scheduler, the floor buttons and the car
// controller. The master side is the scheduler; the slave side is the car/panels.
interface elevator_scheduler_if
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
);

  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    car_floor;
  logic                  car_complete;
  logic [FLOOR_W-1:0]    target_floor;
  logic                  target_valid;
  logic                  sweep_up;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  busy;

  modport master (
    input  call_req, car_floor, car_complete,
    output target_floor, target_valid, sweep_up, door_open, pending, busy
  );

  modport slave (
    output call_req, car_floor, car_complete,
    input  target_floor, target_valid, sweep_up, door_open, pending, busy
  );

endinterface

// File: rtl/elevator_scheduler_scan_pick.sv
// Combinational SCAN target picker: nearest pending floor in the sweep
// direction, reversing the sweep only when nothing lies ahead.
module scan_pick
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  sweep_up,
  output logic                  found,
  output logic [FLOOR_W-1:0]    pick_floor,
  output logic                  new_dir,
  output logic                  here_hit
);

  logic               up_found;
  logic               dn_found;
  logic [FLOOR_W-1:0] up_floor;
  logic [FLOOR_W-1:0] dn_floor;

  // Loop order makes the last match the one closest to car_floor.
  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    here_hit = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) > car_floor)) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < car_floor)) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
      if (pending[i] && (FLOOR_W'(i) == car_floor)) begin
        here_hit = 1'b1;
      end
    end
  end

  always_comb begin
    found      = up_found | dn_found;
    pick_floor = '0;
    new_dir    = sweep_up;
    if (sweep_up) begin
      if (up_found) begin
        pick_floor = up_floor;
      end else if (dn_found) begin
        pick_floor = dn_floor;
        new_dir    = 1'b0;
      end
    end else begin
      if (dn_found) begin
        pick_floor = dn_floor;
      end else if (up_found) begin
        pick_floor = up_floor;
        new_dir    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN hall/car-call scheduler: latches floor calls, dispatches one target at a
// time to the car, holds the door for a fixed time and retires the served call.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int FLOOR_W     = DEF_FLOOR_W,
  parameter int DOOR_CYCLES = DEF_DOOR_CYCLES
) (
  input logic                 clk,
  input logic                 rst,
  elevator_scheduler_if.master bus
);

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  sched_state_t          state, state_next;
  logic [NUM_FLOORS-1:0] pending, pending_next;
  logic [FLOOR_W-1:0]    target_floor, target_floor_next;
  logic                  target_valid, target_valid_next;
  logic                  sweep_up, sweep_up_next;
  logic                  door_open, door_open_next;
  logic                  busy, busy_next;
  logic [CNT_W-1:0]      door_cnt, door_cnt_next;

  logic                  door_exit;
  logic [NUM_FLOORS-1:0] clr_vec;
  logic [NUM_FLOORS-1:0] absorb_vec;

  logic                  pick_found;
  logic [FLOOR_W-1:0]    pick_floor;
  logic                  pick_dir;
  logic                  here_hit;

  scan_pick #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan_pick (
    .pending    (pending),
    .car_floor  (bus.car_floor),
    .sweep_up   (sweep_up),
    .found      (pick_found),
    .pick_floor (pick_floor),
    .new_dir    (pick_dir),
    .here_hit   (here_hit)
  );

  assign door_exit = (state == DOOR) && (door_cnt == '0);

  // Calls at the open-door floor are swallowed so they cannot re-arm the stop.
  always_comb begin
    clr_vec    = '0;
    absorb_vec = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr_vec[i]    = door_exit && (target_floor == FLOOR_W'(i));
      absorb_vec[i] = door_open && (bus.car_floor == FLOOR_W'(i));
    end
  end

  assign pending_next = (pending & ~clr_vec) | (bus.call_req & ~absorb_vec);

  always_comb begin
    state_next        = state;
    target_floor_next = target_floor;
    target_valid_next = target_valid;
    sweep_up_next     = sweep_up;
    door_open_next    = door_open;
    door_cnt_next     = door_cnt;
    case (state)
      IDLE: begin
        if (pending != '0) begin
          state_next = SELECT;
        end
      end
      SELECT: begin
        if (here_hit) begin
          target_floor_next = bus.car_floor;
          target_valid_next = 1'b0;
          door_open_next    = 1'b1;
          door_cnt_next     = CNT_W'(DOOR_CYCLES - 1);
          state_next        = DOOR;
        end else if (pick_found) begin
          target_floor_next = pick_floor;
          sweep_up_next     = pick_dir;
          target_valid_next = 1'b1;
          state_next        = TRAVEL;
        end else begin
          state_next = IDLE;
        end
      end
      TRAVEL: begin
        if (bus.car_complete && (bus.car_floor == target_floor)) begin
          target_valid_next = 1'b0;
          door_open_next    = 1'b1;
          door_cnt_next     = CNT_W'(DOOR_CYCLES - 1);
          state_next        = DOOR;
        end
      end
      DOOR: begin
        if (door_cnt == '0) begin
          door_open_next = 1'b0;
          state_next     = (pending_next != '0) ? SELECT : IDLE;
        end else begin
          door_cnt_next = door_cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      pending      <= '0;
      target_floor <= '0;
      target_valid <= 1'b0;
      sweep_up     <= 1'b1;
      door_open    <= 1'b0;
      door_cnt     <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      pending      <= pending_next;
      target_floor <= target_floor_next;
      target_valid <= target_valid_next;
      sweep_up     <= sweep_up_next;
      door_open    <= door_open_next;
      door_cnt     <= door_cnt_next;
      busy         <= busy_next;
    end
  end

  assign bus.target_floor = target_floor;
  assign bus.target_valid = target_valid;
  assign bus.sweep_up     = sweep_up;
  assign bus.door_open    = door_open;
  assign bus.pending      = pending;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: a vector table for a single-call trip
// plus hand-written sequences for reversal, local calls, absorb and reset.
module tb_elevator_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  elevator_scheduler_if #(.NUM_FLOORS(4), .FLOOR_W(2)) bus ();

  elevator_scheduler #(
    .NUM_FLOORS  (4),
    .FLOOR_W     (2),
    .DOOR_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] call_req;
    logic [1:0] car_floor;
    logic       car_complete;
    logic [9:0] exp_outs;
  } vec_t;

  vec_t vecs[14];

  // Packed output image: {target_floor, target_valid, sweep_up, door_open, pending, busy}.
  function automatic logic [9:0] outs(input logic [1:0] tf, input logic tv, input logic su,
                                      input logic dr, input logic [3:0] p, input logic b);
    return {tf, tv, su, dr, p, b};
  endfunction

  function automatic vec_t mk(input logic [3:0] c, input logic [1:0] f, input logic comp,
                              input logic [9:0] e);
    vec_t v;
    v.call_req     = c;
    v.car_floor    = f;
    v.car_complete = comp;
    v.exp_outs     = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [1:0] f, input logic comp);
    bus.call_req     = c;
    bus.car_floor    = f;
    bus.car_complete = comp;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkAll(input string name, input logic [9:0] exp);
    checkOutput(name, 16'(outs(bus.target_floor, bus.target_valid, bus.sweep_up,
                               bus.door_open, bus.pending, bus.busy)), 16'(exp));
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(4'b0000, 2'd0, 1'b0);
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic waitValid(input string name, input int bound);
    for (int k = 0; k < bound && !bus.target_valid; k++) step();
    checkOutput(name, 16'(bus.target_valid), 16'd1);
  endtask

  // Counts sampled cycles with door_open high, stopping on the first low sample.
  task automatic countDoor(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.door_open) n++;
      else if (n > 0) break;
      step();
    end
  endtask

  initial begin
    int n;
    checks = 0;
    passed = 0;

    vecs[0]  = mk(4'b1000, 2'd2, 1'b0, outs(2'd0, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b0));
    vecs[1]  = mk(4'b0000, 2'd2, 1'b0, outs(2'd0, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1));
    vecs[2]  = mk(4'b0000, 2'd2, 1'b0, outs(2'd3, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1));
    vecs[3]  = mk(4'b0000, 2'd3, 1'b0, outs(2'd3, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1));
    vecs[4]  = mk(4'b0000, 2'd3, 1'b1, outs(2'd3, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1));
    for (int i = 5; i < 12; i++)
      vecs[i] = mk(4'b0000, 2'd3, 1'b0, outs(2'd3, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1));
    vecs[12] = mk(4'b0000, 2'd3, 1'b0, outs(2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));
    vecs[13] = mk(4'b0000, 2'd3, 1'b0, outs(2'd3, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));

    // Reset values, then a quiet idle period.
    rst = 1'b0;
    applyStimulus(4'b0000, 2'd2, 1'b0);
    step();
    checkAll("reset_values", outs(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checkAll($sformatf("idle_%0d", i), outs(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));
    end

    // Single call to floor 3 from floor 2: latency, arrival, 8-cycle door, retire.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].call_req, vecs[i].car_floor, vecs[i].car_complete);
      step();
      checkAll($sformatf("vec_%0d", i), vecs[i].exp_outs);
    end

    // Car at 1 heading up, calls at 0 and 3: serve 3, then reverse to 0.
    doReset();
    applyStimulus(4'b1001, 2'd1, 1'b0);
    step();
    applyStimulus(4'b0000, 2'd1, 1'b0);
    waitValid("rev_first_valid", 10);
    checkOutput("rev_first_target", 16'(bus.target_floor), 16'd3);
    checkOutput("rev_first_dir", 16'(bus.sweep_up), 16'd1);
    applyStimulus(4'b0000, 2'd3, 1'b1);
    step();
    applyStimulus(4'b0000, 2'd3, 1'b0);
    countDoor(n);
    checkOutput("rev_door_len_3", 16'(n), 16'd8);
    checkOutput("rev_pending_after_3", 16'(bus.pending), 16'b0001);
    step();
    checkAll("rev_second_dispatch", outs(2'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1));
    applyStimulus(4'b0000, 2'd0, 1'b1);
    step();
    applyStimulus(4'b0000, 2'd0, 1'b0);
    countDoor(n);
    checkOutput("rev_door_len_0", 16'(n), 16'd8);
    checkAll("rev_done_idle", outs(2'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));

    // Call at the car's own floor: door opens without dispatch.
    doReset();
    applyStimulus(4'b0100, 2'd2, 1'b0);
    step();
    applyStimulus(4'b0000, 2'd2, 1'b0);
    step();
    checkAll("local_select", outs(2'd0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1));
    step();
    checkAll("local_door", outs(2'd2, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1));
    countDoor(n);
    checkOutput("local_door_len", 16'(n), 16'd8);
    checkAll("local_done", outs(2'd2, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));

    // Door at floor 3: floor-3 calls absorbed, floor-0 call latched and served next.
    doReset();
    applyStimulus(4'b1000, 2'd2, 1'b0);
    step();
    applyStimulus(4'b0000, 2'd2, 1'b0);
    waitValid("absorb_valid", 10);
    applyStimulus(4'b0000, 2'd3, 1'b1);
    step();
    bus.car_complete = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.door_open) begin
        n++;
        bus.call_req = (n == 3) ? 4'b1001 : 4'b1000;
      end else begin
        bus.call_req = 4'b0000;
        break;
      end
      step();
    end
    checkOutput("absorb_door_len", 16'(n), 16'd8);
    checkOutput("absorb_pending", 16'(bus.pending), 16'b0001);
    checkOutput("absorb_busy", 16'(bus.busy), 16'd1);
    step();
    checkAll("absorb_next_dispatch", outs(2'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1));

    // Completion from the wrong floor must not end TRAVEL.
    applyStimulus(4'b0000, 2'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkAll($sformatf("wrong_floor_%0d", i), outs(2'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1));
    end
    applyStimulus(4'b0010, 2'd3, 1'b0);
    step();
    checkOutput("travel_accumulate", 16'(bus.pending), 16'b0011);

    // Reset mid-travel drops everything.
    rst = 1'b0;
    applyStimulus(4'b0000, 2'd0, 1'b0);
    step();
    checkAll("reset_mid_travel", outs(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));
    rst = 1'b1;
    step();
    checkAll("after_reset_idle", outs(2'd0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Hall/car-call scheduler that sits in front of the `elevator` car controller.
- Latches floor-button requests from all floors into a pending set and picks the next target using SCAN (sweep direction kept until no calls remain ahead).
- Drives the car's `req_floor` one target at a time, waits for arrival (`complete`), holds the door open for a fixed time, then clears the served call.
- Top-level glue: `target_floor` drives `elevator.req_floor`; `elevator.out_floor` and `elevator.complete` feed `car_floor` and `car_complete`.

Parameters:
- NUM_FLOORS, 4, number of floors served (floor 0 = lowest).
- FLOOR_W, 2, floor index width; requires NUM_FLOORS <= 2**FLOOR_W.
- DOOR_CYCLES, 8, clock cycles the door stays open per stop (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- call_req  input  NUM_FLOORS  one bit per floor, request pulse or level; OR-ed into pending.
- car_floor  input  FLOOR_W  current car floor (elevator out_floor).
- car_complete  input  1  car reports it is at its requested floor (elevator complete).
- target_floor  output  FLOOR_W  floor requested from car (elevator req_floor).
- target_valid  output  1  target_floor is a live dispatch.
- sweep_up  output  1  current SCAN direction: 1 = up, 0 = down.
- door_open  output  1  door-open indication at a served stop.
- pending  output  NUM_FLOORS  registered outstanding-call set.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state = IDLE, pending = 0, target_floor = 0, target_valid = 0, sweep_up = 1, door_open = 0, door counter = 0, busy = 0.
  - Reset mid-travel or mid-door drops all calls. No output is combinational from inputs.
- Pending update, every cycle: pending <= (pending & ~clr) | (call_req & ~absorb).
  - clr: one-hot of target_floor, asserted only in the cycle DOOR exits.
  - absorb: one-hot of car_floor while door_open == 1. A call at the open-door floor is dropped and does not extend the door time.
  - When set and clr hit the same bit, set wins, except for the absorb case.
  - Bits of call_req at or above NUM_FLOORS do not exist; a car_floor value >= NUM_FLOORS is treated as no match.
- FSM states: IDLE, SELECT, TRAVEL, DOOR.
- IDLE: when pending != 0, go to SELECT. Latency: a call_req pulse at edge N sets pending at N+1, SELECT at N+2, target_valid = 1 at N+3.
- SELECT (1 cycle), using registered pending and car_floor:
  - Call at car_floor: target_floor = car_floor, go to DOOR directly. Set door_open = 1 and target_valid = 0; the car is not dispatched.
  - Else if sweep_up: nearest pending floor strictly above car_floor. If none, set sweep_up = 0 and take the nearest strictly below.
  - Else: nearest pending strictly below. If none, set sweep_up = 1 and take the nearest above.
  - Register target_floor, set target_valid = 1, go to TRAVEL.
  - If pending became 0, return to IDLE.
- TRAVEL:
  - Hold target_floor and target_valid stable.
  - Arrival = car_complete && car_floor == target_floor.
  - On arrival: target_valid = 0, door_open = 1, door counter = DOOR_CYCLES-1, go to DOOR.
  - New calls accumulate in pending and do not retarget mid-travel.
- DOOR:
  - Count down. door_open stays high for exactly DOOR_CYCLES cycles.
  - At count 0: door_open = 0, clear pending[target_floor], then go to SELECT if other calls remain, otherwise IDLE.
- sweep_up changes only in SELECT.
- busy = (state != IDLE), registered together with the state.

Decomposition:
- Package elevator_pkg holds:
  - state encoding constants: IDLE = 2'd0, SELECT = 2'd1, TRAVEL = 2'd2, DOOR = 2'd3;
  - default floor count and width;
  - DOOR_CYCLES default.
- Sub-module scan_pick: purely combinational. Inputs pending, car_floor, sweep_up. Outputs found, pick_floor, new_dir, here_hit. Uses a priority search from car_floor outward.
- The top module holds the FSM, pending register and door counter.

Test Plan:
- Reset release, no calls: all outputs 0 except sweep_up = 1; stays IDLE for 20 cycles. Assert rst = 0 during TRAVEL → next edge returns to the reset values and pending = 0.
- Car at floor 2, single call_req = 4'b1000: target_valid rises 3 cycles after the call edge with target_floor = 3. Car reports floor 3 with complete → door_open high exactly 8 cycles, then pending = 0 and the block returns to IDLE.
- Car at 1, sweep_up = 1, calls 4'b1001 in the same cycle: serves 3 first, then sweep_up = 0 and serves 0.
- Call at the current floor (car 2, call_req = 4'b0100 from IDLE): no dispatch (target_valid stays 0), door_open for 8 cycles, bit cleared.
- During DOOR at floor 3: call_req[3] pulse is absorbed (pending[3] stays 0, door time unchanged). call_req[0] in the same window sets pending[0] and is served next.
- complete asserted while car_floor != target_floor: no transition out of TRAVEL.
